// File: rtl/xy_event_monitor_if.sv
// Snapshot handshake bundle between the X/Y event monitor and its consumer.
// The producer owns the snapshot fields and valid; the consumer owns ready.
interface xy_event_monitor_if #(
  parameter int CNT_W = 8
);
  logic [CNT_W-1:0] snap_x;
  logic [CNT_W-1:0] snap_y;
  logic             snap_valid;
  logic             snap_ready;

  modport master (
    output snap_x,
    output snap_y,
    output snap_valid,
    input  snap_ready
  );

  modport slave (
    input  snap_x,
    input  snap_y,
    input  snap_valid,
    output snap_ready
  );
endinterface

// File: rtl/xy_event_monitor.sv
// Synchronises X/Y, counts their rising edges over fixed windows of WINDOW
// cycles and hands each window's counts to a consumer over valid/ready.
module xy_event_monitor #(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    x_in,
  input  logic                    y_in,
  input  logic                    en,
  input  logic                    clr_ovr,
  output logic                    overrun,
  xy_event_monitor_if.master      snap
);

  localparam int TMR_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW - 1);
  localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Saturating increment: a count already at full scale stays there.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                               input logic             inc);
    logic [CNT_W-1:0] result;
    if (inc && (value != CNT_MAX)) begin
      result = value + CNT_ONE;
    end else begin
      result = value;
    end
    return result;
  endfunction

  logic             s1_x_r, s2_x_r, hist_x_r;
  logic             s1_y_r, s2_y_r, hist_y_r;
  logic             rise_x_s, rise_y_s;

  state_t           state_r, state_s;
  logic             run_s;
  logic             win_end_s;

  logic [TMR_W-1:0] timer_r, timer_s;
  logic [CNT_W-1:0] cnt_x_r, cnt_x_s;
  logic [CNT_W-1:0] cnt_y_r, cnt_y_s;
  logic [CNT_W-1:0] inc_x_s, inc_y_s;

  logic [CNT_W-1:0] snap_x_r, snap_x_s;
  logic [CNT_W-1:0] snap_y_r, snap_y_s;
  logic             valid_r, valid_s;
  logic             ovr_r, ovr_s;
  logic             accept_s;
  logic             free_s;

  // Two-flop synchronisers plus one history flop per input for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_x_r   <= 1'b0;
      s2_x_r   <= 1'b0;
      hist_x_r <= 1'b0;
      s1_y_r   <= 1'b0;
      s2_y_r   <= 1'b0;
      hist_y_r <= 1'b0;
    end else begin
      s1_x_r   <= x_in;
      s2_x_r   <= s1_x_r;
      hist_x_r <= s2_x_r;
      s1_y_r   <= y_in;
      s2_y_r   <= s1_y_r;
      hist_y_r <= s2_y_r;
    end
  end

  assign rise_x_s = s2_x_r & ~hist_x_r;
  assign rise_y_s = s2_y_r & ~hist_y_r;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state; windows only advance while RUN and en is still high.
  always_comb begin
    state_s   = state_r;
    run_s     = 1'b0;
    win_end_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (en) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (en) begin
          state_s   = ST_RUN;
          run_s     = 1'b1;
          win_end_s = (timer_r == TMR_LAST);
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  assign inc_x_s  = sat_inc(cnt_x_r, rise_x_s);
  assign inc_y_s  = sat_inc(cnt_y_r, rise_y_s);
  assign accept_s = valid_r & snap.snap_ready;
  assign free_s   = ~valid_r | accept_s;

  // Timer and counters: the final-cycle rise is folded into the snapshot.
  always_comb begin
    timer_s = timer_r;
    cnt_x_s = cnt_x_r;
    cnt_y_s = cnt_y_r;
    if (run_s) begin
      if (win_end_s) begin
        timer_s = TMR_ZERO;
        cnt_x_s = CNT_ZERO;
        cnt_y_s = CNT_ZERO;
      end else begin
        timer_s = timer_r + TMR_ONE;
        cnt_x_s = inc_x_s;
        cnt_y_s = inc_y_s;
      end
    end else begin
      timer_s = TMR_ZERO;
      cnt_x_s = CNT_ZERO;
      cnt_y_s = CNT_ZERO;
    end
  end

  // Snapshot, valid and sticky overrun; a blocked window end drops its data.
  always_comb begin
    snap_x_s = snap_x_r;
    snap_y_s = snap_y_r;
    valid_s  = valid_r;
    ovr_s    = ovr_r;
    if (win_end_s && free_s) begin
      snap_x_s = inc_x_s;
      snap_y_s = inc_y_s;
      valid_s  = 1'b1;
    end else if (accept_s) begin
      valid_s  = 1'b0;
    end else begin
      valid_s  = valid_r;
    end
    if (win_end_s && !free_s) begin
      ovr_s = 1'b1;
    end else if (clr_ovr) begin
      ovr_s = 1'b0;
    end else begin
      ovr_s = ovr_r;
    end
  end

  // Window state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_r  <= TMR_ZERO;
      cnt_x_r  <= CNT_ZERO;
      cnt_y_r  <= CNT_ZERO;
      snap_x_r <= CNT_ZERO;
      snap_y_r <= CNT_ZERO;
      valid_r  <= 1'b0;
      ovr_r    <= 1'b0;
    end else begin
      timer_r  <= timer_s;
      cnt_x_r  <= cnt_x_s;
      cnt_y_r  <= cnt_y_s;
      snap_x_r <= snap_x_s;
      snap_y_r <= snap_y_s;
      valid_r  <= valid_s;
      ovr_r    <= ovr_s;
    end
  end

  assign snap.snap_x     = snap_x_r;
  assign snap.snap_y     = snap_y_r;
  assign snap.snap_valid = valid_r;
  assign overrun         = ovr_r;

endmodule
